// File: rtl/trdb_trace_ctrl.sv
// trdb_trace_ctrl: trace enable/disable sequencer for the trace encoder.
// Freezes a shadow copy of the encoder configuration for the duration of a
// trace session, runs start/stop request/acknowledge handshakes with the
// packet emitter and drains the output path before returning to idle.
//
// Optional feature macro: TRDB_CTRL_TIMEOUT_EN
//   defined   -> handshake watchdog; a request left unacknowledged for TIMEOUT
//                cycles sets the sticky err_timeout_o and advances the FSM.
//   undefined -> START/STOP wait indefinitely; err_timeout_o is tied to 0.
module trdb_trace_ctrl #(
  parameter int unsigned CFG_W     = 10,
  parameter int unsigned ARM_DELAY = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             trace_enable_i,
  input  logic [CFG_W-1:0] cfg_i,
  output logic [CFG_W-1:0] cfg_o,
  output logic             cfg_pending_o,
  output logic             start_req_o,
  input  logic             start_ack_i,
  output logic             stop_req_o,
  input  logic             stop_ack_i,
  input  logic             fifo_empty_i,
  output logic             trace_activated_o,
  output logic             busy_o,
  input  logic             err_clear_i,
  output logic             err_timeout_o
);

  // One shared down-counter serves both the arm delay and the watchdog.
  localparam int unsigned CNT_MAX = (ARM_DELAY > TIMEOUT) ? ARM_DELAY : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ARM_LOAD = CNT_W'(ARM_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_START,
    S_ACTIVE,
    S_STOP,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_dec;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             pending_q, pending_d;

  // Saturating decrement: the counter parks at zero instead of wrapping.
  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

`ifdef TRDB_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT - 1);

  logic err_q, err_d;
  logic err_set;
`else
  // The clear input has no function without the watchdog.
  logic unused_err_clear;
  assign unused_err_clear = err_clear_i;
`endif

  // Next-state, counter and shadow-configuration logic.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
`ifdef TRDB_CTRL_TIMEOUT_EN
    err_set = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        cfg_d = cfg_i;
        if (trace_enable_i) begin
          state_d = S_ARM;
          cnt_d   = ARM_LOAD;
        end
      end
      S_ARM: begin
        if (!trace_enable_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_START;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_START: begin
        if (start_ack_i) begin
          state_d = trace_enable_i ? S_ACTIVE : S_STOP;
`ifdef TRDB_CTRL_TIMEOUT_EN
        end else if (cnt_q == '0) begin
          err_set = 1'b1;
          state_d = trace_enable_i ? S_ACTIVE : S_STOP;
        end else begin
          cnt_d = cnt_dec;
`endif
        end
      end
      S_ACTIVE: begin
        if (!trace_enable_i) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (stop_ack_i) begin
          state_d = S_DRAIN;
`ifdef TRDB_CTRL_TIMEOUT_EN
        end else if (cnt_q == '0) begin
          err_set = 1'b1;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_dec;
`endif
        end
      end
      S_DRAIN: begin
        if (fifo_empty_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef TRDB_CTRL_TIMEOUT_EN
    // Arm the watchdog on every entry into a request state, whichever
    // transition led there (START can fall straight through to STOP).
    if ((state_d == S_START && state_q != S_START) ||
        (state_d == S_STOP  && state_q != S_STOP)) begin
      cnt_d = TO_LOAD;
    end
    // A set in the same cycle as a clear wins.
    err_d = err_set ? 1'b1 : (err_clear_i ? 1'b0 : err_q);
`endif
  end

  // Pending flag is registered so no output depends combinationally on an
  // input; it reflects cfg_i as sampled at the most recent clock edge.
  assign pending_d = (state_d != S_IDLE) && (cfg_i != cfg_d);

  // State, counter, shadow configuration and pending flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cfg_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cfg_q     <= cfg_d;
      pending_q <= pending_d;
    end
  end

`ifdef TRDB_CTRL_TIMEOUT_EN
  // Sticky watchdog error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_timeout_o = err_q;
`else
  assign err_timeout_o = 1'b0;
`endif

  // Moore decodes of the state register.
  assign start_req_o       = (state_q == S_START);
  assign stop_req_o        = (state_q == S_STOP);
  assign trace_activated_o = (state_q == S_ACTIVE);
  assign busy_o            = (state_q != S_IDLE);
  assign cfg_o             = cfg_q;
  assign cfg_pending_o     = pending_q;

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// Self-checking bench for trdb_trace_ctrl: directed scenarios with cycle
// timelines, then randomized traffic checked against a session-level model.
// Cycle c is the interval after clock edge c; inputs driven in cycle c are
// sampled at the edge that ends it.
module tb_trdb_trace_ctrl;

  localparam int CFG_W     = 10;
  localparam int ARM_DELAY = 4;
  localparam int TIMEOUT   = 8;
`ifdef TRDB_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [CFG_W-1:0] cfg_in;
  logic [CFG_W-1:0] cfg_out;
  logic             pending;
  logic             start_req;
  logic             start_ack;
  logic             stop_req;
  logic             stop_ack;
  logic             fifo_empty;
  logic             act;
  logic             busy;
  logic             err_clr;
  logic             err;

  int checks = 0;
  int errors = 0;

  trdb_trace_ctrl #(
    .CFG_W    (CFG_W),
    .ARM_DELAY(ARM_DELAY),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .trace_enable_i   (en),
    .cfg_i            (cfg_in),
    .cfg_o            (cfg_out),
    .cfg_pending_o    (pending),
    .start_req_o      (start_req),
    .start_ack_i      (start_ack),
    .stop_req_o       (stop_req),
    .stop_ack_i       (stop_ack),
    .fifo_empty_i     (fifo_empty),
    .trace_activated_o(act),
    .busy_o           (busy),
    .err_clear_i      (err_clr),
    .err_timeout_o    (err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model: session phase plus cycles spent in that phase.
  // ---------------------------------------------------------------------
  typedef enum int {P_IDLE, P_ARM, P_START, P_ACTIVE, P_STOP, P_DRAIN} phase_e;

  phase_e           m_phase;
  int               m_age;
  logic [CFG_W-1:0] m_cfg;
  logic [CFG_W-1:0] m_cfg_seen;
  logic             m_err;
  wire              m_to = TO_EN && (m_age + 1 == TIMEOUT);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase    <= P_IDLE;
      m_age      <= 0;
      m_cfg      <= '0;
      m_cfg_seen <= '0;
      m_err      <= 1'b0;
    end else begin
      m_cfg_seen <= cfg_in;
      case (m_phase)
        P_IDLE: begin
          m_cfg <= cfg_in;
          if (en) begin m_phase <= P_ARM; m_age <= 0; end
        end
        P_ARM: begin
          if (!en) m_phase <= P_IDLE;
          else if (m_age + 1 == ARM_DELAY) begin m_phase <= P_START; m_age <= 0; end
          else m_age <= m_age + 1;
        end
        P_START: begin
          if (start_ack || m_to) begin
            m_phase <= en ? P_ACTIVE : P_STOP;
            m_age   <= 0;
          end else m_age <= m_age + 1;
        end
        P_ACTIVE: begin
          if (!en) begin m_phase <= P_STOP; m_age <= 0; end
        end
        P_STOP: begin
          if (stop_ack || m_to) m_phase <= P_DRAIN;
          else m_age <= m_age + 1;
        end
        P_DRAIN: begin
          if (fifo_empty) m_phase <= P_IDLE;
        end
        default: m_phase <= P_IDLE;
      endcase
      if (((m_phase == P_START && !start_ack) || (m_phase == P_STOP && !stop_ack)) && m_to)
        m_err <= 1'b1;
      else if (err_clr)
        m_err <= 1'b0;
    end
  end

  task automatic idle_inputs();
    en = 1'b0; start_ack = 1'b0; stop_ack = 1'b0; fifo_empty = 1'b1; err_clr = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_idle(input logic [CFG_W-1:0] cfg);
    idle_inputs();
    cfg_in = cfg;
    repeat (3) next_cycle();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    cfg_in = 10'h3c5;
    #1;
    checks++;
    if ({cfg_out, pending, start_req, stop_req, act, busy, err} !== 16'h0) begin
      errors++;
      $display("FAIL reset_async outs got %h exp 0000",
               {cfg_out, pending, start_req, stop_req, act, busy, err});
    end
    repeat (2) next_cycle();
    checks++;
    if ({cfg_out, pending, start_req, stop_req, act, busy, err} !== 16'h0) begin
      errors++;
      $display("FAIL reset_held outs got %h exp 0000",
               {cfg_out, pending, start_req, stop_req, act, busy, err});
    end
    rst_n = 1'b1;
    next_cycle();
    checks++;
    if (cfg_out !== 10'h3c5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release cfg_o got %h exp 3c5 busy got %b exp 0", cfg_out, busy);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_basic_session();
    logic [3:0] exp;
    settle_idle('0);
    for (int c = 0; c < 28; c++) begin
      next_cycle();
      en         = (c < 20);
      start_ack  = (c == 7);
      stop_ack   = (c == 22);
      fifo_empty = (c >= 25);
      exp = {(c >= 5 && c <= 7), (c >= 21 && c <= 22), (c >= 8 && c <= 20), (c >= 1 && c <= 25)};
      checks++;
      if ({start_req, stop_req, act, busy} !== exp) begin
        errors++;
        $display("FAIL basic c=%0d {start,stop,act,busy} got %b exp %b",
                 c, {start_req, stop_req, act, busy}, exp);
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_abort_arm();
    logic [3:0] exp;
    settle_idle('0);
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      en  = (c < 2);
      exp = {1'b0, 1'b0, 1'b0, (c >= 1 && c <= 2)};
      checks++;
      if ({start_req, stop_req, act, busy} !== exp) begin
        errors++;
        $display("FAIL abort_arm c=%0d {start,stop,act,busy} got %b exp %b",
                 c, {start_req, stop_req, act, busy}, exp);
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_cfg_freeze();
    logic [CFG_W-1:0] exp_cfg;
    logic             exp_pend;
    settle_idle('0);
    for (int c = 0; c < 18; c++) begin
      next_cycle();
      en         = (c < 12);
      start_ack  = (c == 5);
      stop_ack   = (c == 13);
      fifo_empty = (c >= 14);
      cfg_in     = (c >= 8) ? 10'h155 : 10'h000;
      exp_cfg  = (c >= 16) ? 10'h155 : 10'h000;
      exp_pend = (c >= 9 && c <= 14);
      checks++;
      if (cfg_out !== exp_cfg || pending !== exp_pend || act !== (c >= 6 && c <= 12)) begin
        errors++;
        $display("FAIL cfg_freeze c=%0d cfg_o got %h exp %h pending got %b exp %b act got %b",
                 c, cfg_out, exp_cfg, pending, exp_pend, act);
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_enable_drop_start();
    logic [3:0] exp;
    settle_idle('0);
    for (int c = 0; c < 15; c++) begin
      next_cycle();
      en         = (c < 6);
      start_ack  = (c == 8);
      stop_ack   = (c == 10);
      fifo_empty = 1'b1;
      exp = {(c >= 5 && c <= 8), (c >= 9 && c <= 10), 1'b0, (c >= 1 && c <= 11)};
      checks++;
      if ({start_req, stop_req, act, busy} !== exp) begin
        errors++;
        $display("FAIL en_drop_start c=%0d {start,stop,act,busy} got %b exp %b",
                 c, {start_req, stop_req, act, busy}, exp);
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset_mid_stop();
    settle_idle(10'h2aa);
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      en         = (c < 8);
      start_ack  = (c == 5);
      stop_ack   = 1'b0;
      fifo_empty = 1'b0;
    end
    checks++;
    if (stop_req !== 1'b1 || cfg_out !== 10'h2aa) begin
      errors++;
      $display("FAIL rst_stop_pre stop_req got %b exp 1 cfg_o got %h exp 2aa", stop_req, cfg_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_out, pending, start_req, stop_req, act, busy, err} !== 16'h0) begin
      errors++;
      $display("FAIL rst_stop_async outs got %h exp 0000",
               {cfg_out, pending, start_req, stop_req, act, busy, err});
    end
    next_cycle();
    rst_n = 1'b1;
    fifo_empty = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      checks++;
      if (busy !== 1'b0 || stop_req !== 1'b0 || cfg_out !== 10'h2aa) begin
        errors++;
        $display("FAIL rst_stop_after c=%0d busy got %b stop_req got %b cfg_o got %h exp 0 0 2aa",
                 c, busy, stop_req, cfg_out);
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_watchdog();
    logic [4:0] exp;
    settle_idle('0);
    for (int c = 0; c < 26; c++) begin
      next_cycle();
      en         = (c < 17);
      start_ack  = (c == 20);
      stop_ack   = (c == 18 || c == 22);
      err_clr    = (c == 15);
      fifo_empty = 1'b1;
      if (TO_EN)
        exp = {(c >= 5 && c <= 12), (c == 18), (c >= 13 && c <= 17), (c >= 1 && c <= 19),
               (c >= 13 && c <= 15)};
      else
        exp = {(c >= 5 && c <= 20), (c >= 21 && c <= 22), 1'b0, (c >= 1 && c <= 23), 1'b0};
      checks++;
      if ({start_req, stop_req, act, busy, err} !== exp) begin
        errors++;
        $display("FAIL watchdog c=%0d {start,stop,act,busy,err} got %b exp %b",
                 c, {start_req, stop_req, act, busy, err}, exp);
      end
    end
    err_clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_random();
    logic [4:0]       exp;
    logic             exp_pend;
    settle_idle('0);
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      exp = {m_phase == P_START, m_phase == P_STOP, m_phase == P_ACTIVE,
             m_phase != P_IDLE, m_err};
      exp_pend = (m_phase != P_IDLE) && (m_cfg_seen != m_cfg);
      checks++;
      if ({start_req, stop_req, act, busy, err} !== exp || cfg_out !== m_cfg ||
          pending !== exp_pend) begin
        errors++;
        $display("FAIL random c=%0d {start,stop,act,busy,err} got %b exp %b cfg_o got %h exp %h pending got %b exp %b",
                 c, {start_req, stop_req, act, busy, err}, exp, cfg_out, m_cfg, pending, exp_pend);
      end
      if ($urandom_range(9) == 0) en = ~en;
      start_ack  = ($urandom_range(5) == 0);
      stop_ack   = ($urandom_range(5) == 0);
      fifo_empty = ($urandom_range(2) == 0);
      err_clr    = ($urandom_range(15) == 0);
      if ($urandom_range(7) == 0) cfg_in = CFG_W'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_basic_session();
    test_abort_arm();
    test_cfg_freeze();
    test_enable_drop_start();
    test_reset_mid_stop();
    test_watchdog();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "bench time limit reached");
  end

endmodule
